// File: rtl/mem_access_ctrl_if.sv
// Request/acknowledge bus between the MEM-stage access sequencer and a
// multi-cycle data memory. The sequencer is the master, the memory the slave.
interface mem_access_ctrl_if;
   logic        MemReq;
   logic        MemWe;
   logic [31:0] MemAddr;
   logic [31:0] MemWData;
   logic [31:0] MemRData;
   logic        MemAck;

   modport master (
      output MemReq, MemWe, MemAddr, MemWData,
      input  MemRData, MemAck
   );

   modport slave (
      input  MemReq, MemWe, MemAddr, MemWData,
      output MemRData, MemAck
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer for the 5-stage RV32I pipeline.
// Latches the EX/MEM access into a req/ack transaction, stalls the pipeline
// until it completes, captures load data and flags misaligned or timed-out
// accesses with a one-cycle MemErr pulse.
module mem_access_ctrl #(
   parameter int TIMEOUT     = 16,
   parameter bit CHECK_ALIGN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MemWriteM,
   input  logic [1:0]        ResultSrcM,
   input  logic [31:0]       ALUResultM,
   input  logic [31:0]       WriteDataM,
   mem_access_ctrl_if.master mem,
   output logic              StallMem,
   output logic [31:0]       ReadDataM,
   output logic              MemErr
);

   // Counter must hold 0..TIMEOUT; keep at least one bit when the timeout is disabled.
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic          req_reg, req_next;
   logic          we_reg, we_next;
   logic [31:0]   addr_reg, addr_next;
   logic [31:0]   wdata_reg, wdata_next;
   logic [31:0]   rdata_reg, rdata_next;
   logic          err_reg, err_next;

   logic access;
   logic is_load;
   logic misaligned;

   // A store takes priority when both the store and load indications are set.
   assign access     = MemWriteM | (ResultSrcM == 2'b01);
   assign is_load    = ~MemWriteM & (ResultSrcM == 2'b01);
   assign misaligned = CHECK_ALIGN & (ALUResultM[1:0] != 2'b00);

   assign mem.MemReq   = req_reg;
   assign mem.MemWe    = we_reg;
   assign mem.MemAddr  = addr_reg;
   assign mem.MemWData = wdata_reg;
   assign ReadDataM    = rdata_reg;
   assign MemErr       = err_reg;

   // State and registered-output update; reset abandons any access in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         req_reg   <= 1'b0;
         we_reg    <= 1'b0;
         addr_reg  <= 32'd0;
         wdata_reg <= 32'd0;
         rdata_reg <= 32'd0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         req_reg   <= req_next;
         we_reg    <= we_next;
         addr_reg  <= addr_next;
         wdata_reg <= wdata_next;
         rdata_reg <= rdata_next;
         err_reg   <= err_next;
      end
   end

   // Next-state, next-output and stall decode.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      req_next   = req_reg;
      we_next    = we_reg;
      addr_next  = addr_reg;
      wdata_next = wdata_reg;
      rdata_next = rdata_reg;
      err_next   = 1'b0;
      StallMem   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (access) begin
               if (misaligned) begin
                  // Retire as a no-op: no request, no stall, just the error pulse.
                  err_next = 1'b1;
                  if (is_load) begin
                     rdata_next = 32'd0;
                  end
               end else begin
                  StallMem   = 1'b1;
                  addr_next  = ALUResultM;
                  wdata_next = WriteDataM;
                  we_next    = MemWriteM;
                  req_next   = 1'b1;
                  state_next = BUSY;
               end
            end
         end
         BUSY: begin
            StallMem = 1'b1;
            // Ack is tested before the timeout so an ack on the last cycle still succeeds.
            if (mem.MemAck) begin
               req_next   = 1'b0;
               cnt_next   = '0;
               state_next = DONE;
               if (!we_reg) begin
                  rdata_next = mem.MemRData;
               end
            end else if (TIMEOUT != 0) begin
               if (cnt_reg == CNT_LAST) begin
                  req_next   = 1'b0;
                  err_next   = 1'b1;
                  cnt_next   = '0;
                  state_next = DONE;
                  if (!we_reg) begin
                     rdata_next = 32'd0;
                  end
               end else begin
                  cnt_next = cnt_reg + CW'(1);
               end
            end
         end
         DONE: begin
            // Inputs still describe the finished instruction, so they are ignored here.
            cnt_next   = '0;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl. Two instances: index 0 uses
// TIMEOUT=4 with alignment checking, index 1 uses TIMEOUT=0 without it.
module tb_mem_access_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst = 1'b1;
   logic [1:0]        mwe = '0;
   logic [1:0][1:0]   rsrc = '0;
   logic [1:0][31:0]  alu = '0;
   logic [1:0][31:0]  wd = '0;
   logic [1:0][31:0]  rdata_i = '0;
   logic [1:0]        ack_i = '0;

   logic [1:0]        stall_o;
   logic [1:0]        err_o;
   logic [1:0]        req_o;
   logic [1:0]        we_o;
   logic [1:0][31:0]  rd_o;
   logic [1:0][31:0]  addr_o;
   logic [1:0][31:0]  wdata_o;

   mem_access_ctrl_if bus0 ();
   mem_access_ctrl_if bus1 ();

   assign bus0.MemAck   = ack_i[0];
   assign bus0.MemRData = rdata_i[0];
   assign bus1.MemAck   = ack_i[1];
   assign bus1.MemRData = rdata_i[1];
   assign req_o[0]   = bus0.MemReq;
   assign we_o[0]    = bus0.MemWe;
   assign addr_o[0]  = bus0.MemAddr;
   assign wdata_o[0] = bus0.MemWData;
   assign req_o[1]   = bus1.MemReq;
   assign we_o[1]    = bus1.MemWe;
   assign addr_o[1]  = bus1.MemAddr;
   assign wdata_o[1] = bus1.MemWData;

   mem_access_ctrl #(.TIMEOUT(4), .CHECK_ALIGN(1'b1)) dut0 (
      .clk        (clk),
      .rst        (rst),
      .MemWriteM  (mwe[0]),
      .ResultSrcM (rsrc[0]),
      .ALUResultM (alu[0]),
      .WriteDataM (wd[0]),
      .mem        (bus0.master),
      .StallMem   (stall_o[0]),
      .ReadDataM  (rd_o[0]),
      .MemErr     (err_o[0])
   );

   mem_access_ctrl #(.TIMEOUT(0), .CHECK_ALIGN(1'b0)) dut1 (
      .clk        (clk),
      .rst        (rst),
      .MemWriteM  (mwe[1]),
      .ResultSrcM (rsrc[1]),
      .ALUResultM (alu[1]),
      .WriteDataM (wd[1]),
      .mem        (bus1.master),
      .StallMem   (stall_o[1]),
      .ReadDataM  (rd_o[1]),
      .MemErr     (err_o[1])
   );

   int n_checks = 0;
   int n_pass   = 0;
   logic [1:0][31:0] model_rd = '0;

   typedef struct {
      int          occ;
      int          stall;
      int          req;
      int          err;
      logic [31:0] rd;
   } exp_t;

   // Reference model: outcome of one MEM-stage instruction from the access rules.
   function automatic exp_t predict(input int timeout, input bit check_align,
                                    input logic we, input logic ld,
                                    input logic [31:0] addr, input logic [31:0] rdata,
                                    input logic [31:0] prev_rd, input int ack_after);
      exp_t e;
      int   busy;
      bit   ok;
      e.rd = prev_rd;
      if (!we && !ld) begin
         e.occ = 1; e.stall = 0; e.req = 0; e.err = 0;
      end else if (check_align && addr[1:0] != 2'b00) begin
         e.occ = 1; e.stall = 0; e.req = 0; e.err = 1;
         if (!we) e.rd = 32'd0;
      end else begin
         if (ack_after >= 0 && (timeout == 0 || ack_after < timeout)) begin
            busy = ack_after + 1; ok = 1'b1;
         end else begin
            busy = timeout; ok = 1'b0;
         end
         e.occ = busy + 2; e.stall = busy + 1; e.req = busy; e.err = ok ? 0 : 1;
         if (!we) e.rd = ok ? rdata : 32'd0;
      end
      return e;
   endfunction

   // Presents one instruction to instance sel, holds it while stalled, plays the
   // memory (ack after ack_after BUSY cycles, -1 = never) and records what was seen.
   task automatic run_op(input bit sel, input logic we, input logic ld,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int ack_after, input bit spurious,
                         output int n_occ, output int n_stall, output int n_req,
                         output int n_err, output int n_bad_bus,
                         output logic [31:0] rd_leave, output logic [31:0] rd_after);
      int busy_k = 0;
      int post   = 0;
      bit left   = 1'b0;
      n_occ = 0; n_stall = 0; n_req = 0; n_err = 0; n_bad_bus = 0;
      rd_leave = 32'd0; rd_after = 32'd0;
      for (int c = 0; c < 60; c++) begin
         @(posedge clk); #1;
         if (c == 0) begin
            mwe[sel] = we; rsrc[sel] = ld ? 2'b01 : 2'b00; alu[sel] = addr; wd[sel] = wdata;
         end else if (left) begin
            mwe[sel] = 1'b0; rsrc[sel] = 2'b00; alu[sel] = $urandom; wd[sel] = $urandom;
         end
         if (req_o[sel]) begin
            ack_i[sel]   = (busy_k == ack_after);
            rdata_i[sel] = (busy_k == ack_after) ? rdata : $urandom;
            busy_k++;
         end else begin
            ack_i[sel]   = spurious & 1'($urandom_range(0, 1));
            rdata_i[sel] = $urandom;
         end
         #1;
         if (stall_o[sel]) n_stall++;
         if (err_o[sel]) n_err++;
         if (req_o[sel]) begin
            n_req++;
            if (addr_o[sel] !== addr || we_o[sel] !== we || wdata_o[sel] !== wdata) n_bad_bus++;
         end
         if (!left) begin
            n_occ++;
            if (!stall_o[sel]) begin
               left = 1'b1;
               rd_leave = rd_o[sel];
            end
         end else begin
            post++;
            if (post == 1) rd_after = rd_o[sel];
            if (post == 3) break;
         end
      end
      ack_i[sel] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      mwe = '0; rsrc = '0; ack_i = '0;
      repeat (2) @(posedge clk);
      #2;
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if ({req_o[i], we_o[i], err_o[i], stall_o[i], addr_o[i], wdata_o[i], rd_o[i]} !== '0)
            $display("FAIL reset_state dut%0d: req=%b we=%b err=%b stall=%b addr=%h wdata=%h rd=%h, required all 0",
                     i, req_o[i], we_o[i], err_o[i], stall_o[i], addr_o[i], wdata_o[i], rd_o[i]);
         else n_pass++;
      end
      rst = 1'b0;
      model_rd = '0;
      $display("reset: both instances checked for zeroed outputs");
   endtask

   task automatic test_store();
      int occ, st, rq, er, bad;
      logic [31:0] rl, ra;
      run_op(1'b0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1'b0, occ, st, rq, er, bad, rl, ra);
      n_checks++;
      if (st !== 2) $display("FAIL store_stall: got %0d cycles, required 2", st); else n_pass++;
      n_checks++;
      if (rq !== 1) $display("FAIL store_req: got %0d cycles, required 1", rq); else n_pass++;
      n_checks++;
      if (bad !== 0) $display("FAIL store_bus: %0d cycles with wrong addr/we/wdata, required 0", bad); else n_pass++;
      n_checks++;
      if (occ !== 3 || er !== 0) $display("FAIL store_done: occupancy %0d err %0d, required 3 and 0", occ, er); else n_pass++;
      $display("store 0x100 <= 0xDEADBEEF: occ=%0d stall=%0d req=%0d err=%0d", occ, st, rq, er);
   endtask

   task automatic test_load_wait();
      int occ, st, rq, er, bad;
      logic [31:0] rl, ra;
      run_op(1'b0, 1'b0, 1'b1, 32'h204, 32'h0, 32'h12345678, 3, 1'b0, occ, st, rq, er, bad, rl, ra);
      model_rd[0] = 32'h12345678;
      n_checks++;
      if (rq !== 4 || bad !== 0) $display("FAIL load_req: req %0d cycles, %0d unstable, required 4 and 0", rq, bad); else n_pass++;
      n_checks++;
      if (st !== 5) $display("FAIL load_stall: got %0d cycles, required 5", st); else n_pass++;
      n_checks++;
      if (rl !== 32'h12345678) $display("FAIL load_data: ReadDataM %h in DONE, required 12345678", rl); else n_pass++;
      $display("load 0x204 wait 3: occ=%0d stall=%0d req=%0d rd=%h", occ, st, rq, rl);
   endtask

   task automatic test_misaligned();
      int occ, st, rq, er, bad;
      logic [31:0] rl, ra;
      run_op(1'b0, 1'b0, 1'b1, 32'h102, 32'h0, 32'hAAAA5555, 0, 1'b0, occ, st, rq, er, bad, rl, ra);
      model_rd[0] = 32'd0;
      n_checks++;
      if (rq !== 0 || st !== 0) $display("FAIL misalign_noreq: req %0d stall %0d cycles, required 0 and 0", rq, st); else n_pass++;
      n_checks++;
      if (er !== 1) $display("FAIL misalign_err: MemErr high %0d cycles, required 1", er); else n_pass++;
      n_checks++;
      if (ra !== 32'd0) $display("FAIL misalign_rd: ReadDataM %h, required 0", ra); else n_pass++;
      $display("misaligned load 0x102 (align check on): req=%0d err=%0d rd=%h", rq, er, ra);
      run_op(1'b1, 1'b0, 1'b1, 32'h102, 32'h0, 32'hCAFEF00D, 1, 1'b0, occ, st, rq, er, bad, rl, ra);
      model_rd[1] = 32'hCAFEF00D;
      n_checks++;
      if (rq !== 2 || bad !== 0 || er !== 0) $display("FAIL noalign_req: req %0d bad %0d err %0d, required 2 0 0", rq, bad, er); else n_pass++;
      n_checks++;
      if (rl !== 32'hCAFEF00D) $display("FAIL noalign_data: ReadDataM %h, required cafef00d", rl); else n_pass++;
      $display("load 0x102 (align check off): req=%0d rd=%h", rq, rl);
   endtask

   task automatic test_timeout();
      int occ, st, rq, er, bad;
      logic [31:0] rl, ra;
      run_op(1'b0, 1'b0, 1'b1, 32'h300, 32'h0, 32'h0, -1, 1'b1, occ, st, rq, er, bad, rl, ra);
      model_rd[0] = 32'd0;
      n_checks++;
      if (rq !== 4) $display("FAIL timeout_req: req %0d cycles, required 4", rq); else n_pass++;
      n_checks++;
      if (er !== 1) $display("FAIL timeout_err: MemErr high %0d cycles, required 1", er); else n_pass++;
      n_checks++;
      if (occ !== 6 || rl !== 32'd0) $display("FAIL timeout_done: occupancy %0d rd %h, required 6 and 0", occ, rl); else n_pass++;
      $display("timeout load 0x300: occ=%0d req=%0d err=%0d", occ, rq, er);
      run_op(1'b1, 1'b1, 1'b0, 32'h310, 32'h5A5A5A5A, 32'h0, 20, 1'b1, occ, st, rq, er, bad, rl, ra);
      n_checks++;
      if (rq !== 21 || er !== 0 || bad !== 0) $display("FAIL notimeout_wait: req %0d err %0d bad %0d, required 21 0 0", rq, er, bad); else n_pass++;
      $display("store 0x310 wait 20 (timeout off): req=%0d err=%0d", rq, er);
   endtask

   task automatic test_back_to_back();
      logic [31:0] a [2];
      logic [31:0] r [2];
      logic [31:0] seen [2];
      int idx = 0, occ = 0, reqs = 0, acks = 0, bad = 0, post = 0;
      a[0] = 32'h500; a[1] = 32'h504;
      r[0] = $urandom; r[1] = $urandom;
      seen[0] = 32'd0; seen[1] = 32'd0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         if (idx < 2) begin
            mwe[0] = 1'b0; rsrc[0] = 2'b01; alu[0] = a[idx]; wd[0] = 32'd0;
         end else begin
            mwe[0] = 1'b0; rsrc[0] = 2'b00; alu[0] = $urandom;
         end
         ack_i[0]   = req_o[0];
         rdata_i[0] = (acks < 2) ? r[acks] : $urandom;
         #1;
         if (req_o[0]) begin
            reqs++;
            if (acks < 2 && addr_o[0] !== a[acks]) bad++;
            acks++;
         end
         if (idx < 2) begin
            occ++;
            if (!stall_o[0]) begin
               seen[idx] = rd_o[0];
               idx++;
            end
         end else begin
            post++;
            if (post == 3) break;
         end
      end
      ack_i[0] = 1'b0;
      model_rd[0] = r[1];
      n_checks++;
      if (occ !== 6) $display("FAIL b2b_occupancy: %0d cycles for two loads, required 6", occ); else n_pass++;
      n_checks++;
      if (reqs !== 2 || bad !== 0) $display("FAIL b2b_reqs: %0d request cycles, %0d wrong addr, required 2 and 0", reqs, bad); else n_pass++;
      n_checks++;
      if (seen[0] !== r[0] || seen[1] !== r[1])
         $display("FAIL b2b_data: got %h %h, required %h %h", seen[0], seen[1], r[0], r[1]);
      else n_pass++;
      $display("back-to-back loads 0x500/0x504: occ=%0d reqs=%0d rd=%h,%h", occ, reqs, seen[0], seen[1]);
   endtask

   task automatic test_reset_mid();
      int occ, st, rq, er, bad;
      logic [31:0] rl, ra;
      @(posedge clk); #1;
      mwe[0] = 1'b0; rsrc[0] = 2'b01; alu[0] = 32'h400; ack_i[0] = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_checks++;
      if (req_o[0] !== 1'b1) $display("FAIL midreset_busy: MemReq %b in 2nd BUSY cycle, required 1", req_o[0]); else n_pass++;
      rst = 1'b1;
      rsrc[0] = 2'b00; alu[0] = 32'd0;
      @(posedge clk); #2;
      n_checks++;
      if ({req_o[0], we_o[0], err_o[0], stall_o[0], addr_o[0], wdata_o[0], rd_o[0]} !== '0)
         $display("FAIL midreset_state: req=%b we=%b err=%b stall=%b addr=%h wdata=%h rd=%h, required all 0",
                  req_o[0], we_o[0], err_o[0], stall_o[0], addr_o[0], wdata_o[0], rd_o[0]);
      else n_pass++;
      rst = 1'b0;
      model_rd = '0;
      run_op(1'b0, 1'b1, 1'b0, 32'h40C, 32'h0BADCAFE, 32'h0, 1, 1'b0, occ, st, rq, er, bad, rl, ra);
      n_checks++;
      if (rq !== 2 || st !== 3 || er !== 0 || bad !== 0)
         $display("FAIL midreset_after: req %0d stall %0d err %0d bad %0d, required 2 3 0 0", rq, st, er, bad);
      else n_pass++;
      $display("reset in 2nd BUSY cycle, then store 0x40C: req=%0d stall=%0d", rq, st);
   endtask

   task automatic test_random();
      int occ, st, rq, er, bad;
      logic [31:0] rl, ra, addr, wdata, rdata;
      logic we, ld;
      int ack_after, kind;
      bit sel;
      exp_t e;
      for (int n = 0; n < 40; n++) begin
         sel  = 1'($urandom_range(0, 1));
         kind = $urandom_range(0, 7);
         we   = (kind == 2 || kind == 3 || kind == 6);
         ld   = (kind == 1 || kind == 3 || kind == 4 || kind == 5);
         addr = $urandom;
         if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
         wdata = $urandom;
         rdata = $urandom;
         if (sel == 1'b0) ack_after = ($urandom_range(0, 5) == 5) ? -1 : $urandom_range(0, 5);
         else             ack_after = $urandom_range(0, 6);
         e = predict(sel ? 0 : 4, sel ? 1'b0 : 1'b1, we, ld, addr, rdata, model_rd[sel], ack_after);
         run_op(sel, we, ld, addr, wdata, rdata, ack_after, 1'($urandom_range(0, 1)),
                occ, st, rq, er, bad, rl, ra);
         model_rd[sel] = e.rd;
         n_checks++;
         if (occ !== e.occ || st !== e.stall)
            $display("FAIL rand%0d_timing: occ %0d stall %0d, required %0d %0d", n, occ, st, e.occ, e.stall);
         else n_pass++;
         n_checks++;
         if (rq !== e.req || bad !== 0)
            $display("FAIL rand%0d_req: req %0d bad %0d, required %0d 0", n, rq, bad, e.req);
         else n_pass++;
         n_checks++;
         if (er !== e.err) $display("FAIL rand%0d_err: MemErr %0d cycles, required %0d", n, er, e.err); else n_pass++;
         n_checks++;
         if (ra !== e.rd) $display("FAIL rand%0d_rd: ReadDataM %h, required %h", n, ra, e.rd); else n_pass++;
         $display("rand%0d dut%0d we=%b ld=%b addr=%h ack_after=%0d: occ=%0d req=%0d err=%0d rd=%h",
                  n, sel, we, ld, addr, ack_after, occ, rq, er, ra);
      end
   endtask

   initial begin
      test_reset();
      test_store();
      test_load_wait();
      test_misaligned();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
